io_ff_bank: RTL

- Parametrised successor of the single-bit IO tile flip-flop: a bank of WIDTH IO data registers.
- Per-channel 2-bit mode select: bypass, registered, 2-stage synchroniser, or registered with clock-enable hold.
- Modes are loaded through a serial configuration chain (ccff_head/ccff_tail) and applied atomically from a shadow register.
- Sits in the IO logical tile between the pad and routing. It replaces one-FF-per-pad instantiation. Scan shift and config shift share the single fabric clock.

---
 rtl/io_ff_bank_pkg.sv | 22 ++
 rtl/io_ff_bank_ccff_chain.sv | 76 +++++++
 rtl/io_ff_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/io_ff_bank_pkg.sv
// Shared types and helpers for the io_ff_bank IO register bank.
// IO_FF_BANK_CFG_PARITY_EN adds an even-parity bit to the configuration chain.
package io_ff_bank_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    IOFF_BYPASS = 2'd0,
    IOFF_REG    = 2'd1,
    IOFF_SYNC2  = 2'd2,
    IOFF_HOLD   = 2'd3
  } ioff_mode_e;

  function automatic int chain_len(input int width);
`ifdef IO_FF_BANK_CFG_PARITY_EN
    return MODE_W * width + 1;
`else
    return MODE_W * width;
`endif
  endfunction

endpackage

// File: rtl/io_ff_bank_ccff_chain.sv
// Serial configuration chain with a shadow mode register loaded when config_enable falls.
// With IO_FF_BANK_CFG_PARITY_EN, a load whose chain parity is odd is rejected and flagged.
module io_ff_bank_ccff_chain
  import io_ff_bank_pkg::*;
#(
  parameter int                WIDTH      = 4,
  parameter logic [MODE_W-1:0] RESET_MODE = 2'b00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    config_enable,
  input  logic                    ccff_head,
  output logic [MODE_W*WIDTH-1:0] o_modes,
  output logic                    ccff_tail,
  output logic                    cfg_err
);

  localparam int CL = chain_len(WIDTH);
  localparam int MW = MODE_W * WIDTH;

  logic [CL-1:0] r_chain;
  logic          r_cfg_en_d;
  logic [MW-1:0] r_modes;
  logic          w_load;

  assign w_load = r_cfg_en_d & ~config_enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain    <= '0;
      r_cfg_en_d <= 1'b0;
    end else begin
      r_cfg_en_d <= config_enable;
      if (config_enable) begin
        r_chain <= {r_chain[CL-2:0], ccff_head};
      end
    end
  end

`ifdef IO_FF_BANK_CFG_PARITY_EN
  logic r_cfg_err;
  logic w_parity_bad;

  assign w_parity_bad = ^r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_modes   <= {WIDTH{RESET_MODE}};
      r_cfg_err <= 1'b0;
    end else if (w_load) begin
      // A corrupt word leaves the previously applied modes in place.
      if (w_parity_bad) begin
        r_cfg_err <= 1'b1;
      end else begin
        r_modes <= r_chain[MW-1:0];
      end
    end
  end

  assign cfg_err = r_cfg_err;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_modes <= {WIDTH{RESET_MODE}};
    end else if (w_load) begin
      r_modes <= r_chain;
    end
  end

  assign cfg_err = 1'b0;
`endif

  assign o_modes   = r_modes;
  assign ccff_tail = r_chain[CL-1];

endmodule

// File: rtl/io_ff_bank.sv
// Bank of WIDTH IO data registers with per-channel bypass/REG/SYNC2/HOLD modes and scan.
// Optional config parity checking is enabled by IO_FF_BANK_CFG_PARITY_EN.
module io_ff_bank
  import io_ff_bank_pkg::*;
#(
  parameter int                WIDTH      = 4,
  parameter logic [MODE_W-1:0] RESET_MODE = 2'b00
) (
  input  logic             ff_clk,
  input  logic             ff_reset_n,
  input  logic [WIDTH-1:0] ff_D,
  input  logic [WIDTH-1:0] ff_ce,
  input  logic             ff_clr,
  input  logic             test_en,
  input  logic             scan_mode,
  input  logic             ff_SI,
  output logic             ff_SO,
  input  logic             config_enable,
  input  logic             ccff_head,
  output logic             ccff_tail,
  output logic [WIDTH-1:0] ff_Q,
  output logic             cfg_err
);

  logic [MODE_W*WIDTH-1:0] w_modes;
  logic [WIDTH-1:0]        r_s1;
  logic [WIDTH-1:0]        r_s2;
  logic [WIDTH-1:0]        w_s1_next;
  logic [WIDTH-1:0]        w_s2_next;

  io_ff_bank_ccff_chain #(
    .WIDTH      (WIDTH),
    .RESET_MODE (RESET_MODE)
  ) u_chain (
    .clk           (ff_clk),
    .rst_n         (ff_reset_n),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .o_modes       (w_modes),
    .ccff_tail     (ccff_tail),
    .cfg_err       (cfg_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      ioff_mode_e w_mode;
      ioff_mode_e w_out_mode;
      logic       w_scan_src;
      logic       w_q;

      assign w_mode     = ioff_mode_e'(w_modes[MODE_W*gi +: MODE_W]);
      assign w_out_mode = scan_mode ? IOFF_REG : w_mode;

      if (gi == 0) begin : g_first
        assign w_scan_src = ff_SI;
      end else begin : g_rest
        assign w_scan_src = r_s1[gi-1];
      end

      // Priority: config hold, scan shift, clear, then functional capture.
      assign w_s1_next[gi] = config_enable                          ? r_s1[gi]   :
                             test_en                                ? w_scan_src :
                             ff_clr                                 ? 1'b0       :
                             (w_mode == IOFF_HOLD && !ff_ce[gi])    ? r_s1[gi]   :
                                                                      ff_D[gi];

      // Stage 2 always trails stage 1 so switching into SYNC2 needs no flush.
      assign w_s2_next[gi] = config_enable       ? r_s2[gi] :
                             (ff_clr && !test_en) ? 1'b0     :
                                                    r_s1[gi];

      always_comb begin
        w_q = ff_D[gi];
        case (w_out_mode)
          IOFF_BYPASS: w_q = ff_D[gi];
          IOFF_REG:    w_q = r_s1[gi];
          IOFF_SYNC2:  w_q = r_s2[gi];
          IOFF_HOLD:   w_q = r_s1[gi];
          default:     w_q = ff_D[gi];
        endcase
      end

      assign ff_Q[gi] = w_q;
    end
  endgenerate

  always_ff @(posedge ff_clk or negedge ff_reset_n) begin
    if (!ff_reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_s1_next;
      r_s2 <= w_s2_next;
    end
  end

  assign ff_SO = r_s1[WIDTH-1];

endmodule
